// File: rtl/pwm_ramp_seq.sv
// Wishbone master that ramps the pwm_wb threshold registers toward programmed targets.
// Channels waiting for a write share the bus round-robin; one write per channel per tick.
module pwm_ramp_seq #(
    parameter int          NCH         = 8,
    parameter logic [31:0] BASE_ADR    = 32'hFEED_0000,
    parameter int          TICK_DIV    = 1024,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   cfg_valid_i,
    input  logic [$clog2(NCH)-1:0] cfg_ch_i,
    input  logic [7:0]             cfg_target_i,
    input  logic [7:0]             cfg_step_i,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [3:0]             wbm_sel_o,
    output logic [31:0]            wbm_adr_o,
    output logic [31:0]            wbm_dat_o,
    input  logic                   wbm_ack_i,
    output logic [NCH-1:0]         active_o,
    output logic                   irq_o,
    output logic                   err_o
);

    localparam int CH_W  = $clog2(NCH);
    localparam int TK_W  = $clog2(TICK_DIV + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

    state_t            state, state_next;
    logic [7:0]        cur  [NCH];
    logic [7:0]        tgt  [NCH];
    logic [7:0]        step [NCH];
    logic [NCH-1:0]    pending;
    logic [TK_W-1:0]   tick_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   bus_ch;
    logic [7:0]        bus_nxt;
    logic [31:0]       adr_q;

    logic              tick_wrap;
    logic              found;
    logic [CH_W-1:0]   cand;
    logic [CH_W-1:0]   sel_ch;
    logic [7:0]        sel_cur, sel_tgt, sel_step, diff, nxt;
    logic              bus_on, do_ack, do_timeout;
    logic [CH_W-1:0]   rr_after;

    assign tick_wrap = (tick_cnt == TK_W'(TICK_DIV - 1));
    assign rr_after  = (bus_ch == CH_W'(NCH - 1)) ? '0 : bus_ch + 1'b1;

    // First pending channel at or after the round-robin pointer.
    always_comb begin
        found  = 1'b0;
        sel_ch = '0;
        cand   = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = CH_W'((int'(rr_ptr) + i) % NCH);
            if (!found && pending[cand]) begin
                found  = 1'b1;
                sel_ch = cand;
            end
        end
    end

    // One step toward the target, clamped so it never passes it.
    always_comb begin
        sel_cur  = cur[sel_ch];
        sel_tgt  = tgt[sel_ch];
        sel_step = step[sel_ch];
        diff     = (sel_tgt >= sel_cur) ? sel_tgt - sel_cur : sel_cur - sel_tgt;
        nxt      = sel_tgt;
        if (sel_step != 8'd0 && sel_step < diff) begin
            nxt = (sel_tgt > sel_cur) ? sel_cur + sel_step : sel_cur - sel_step;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus_on     = 1'b0;
        do_ack     = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE:  if (|pending) state_next = SCAN;
            SCAN:  state_next = found ? WRITE : IDLE;
            WRITE: begin
                bus_on = 1'b1;
                if (wbm_ack_i) begin
                    do_ack     = 1'b1;
                    state_next = IDLE;
                end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    do_timeout = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wbm_cyc_o = bus_on;
    assign wbm_stb_o = bus_on;
    assign wbm_we_o  = bus_on;
    assign wbm_sel_o = bus_on ? 4'b1111 : 4'b0000;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = {24'b0, bus_nxt};

    // Later assignments to pending win: ack clears, then a jump config re-arms.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int n = 0; n < NCH; n++) begin
                cur[n]  <= '0;
                tgt[n]  <= '0;
                step[n] <= '0;
            end
            pending  <= '0;
            tick_cnt <= '0;
            to_cnt   <= '0;
            rr_ptr   <= '0;
            bus_ch   <= '0;
            bus_nxt  <= '0;
            adr_q    <= '0;
            active_o <= '0;
            irq_o    <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
            irq_o    <= 1'b0;
            for (int n = 0; n < NCH; n++) begin
                active_o[n] <= (cur[n] != tgt[n]);
                if (tick_wrap && (cur[n] != tgt[n])) pending[n] <= 1'b1;
            end
            if (state == SCAN && found) begin
                bus_ch  <= sel_ch;
                bus_nxt <= nxt;
                adr_q   <= BASE_ADR | 32'(sel_ch);
                to_cnt  <= '0;
            end
            if (state == WRITE && !wbm_ack_i) to_cnt <= to_cnt + 1'b1;
            if (do_ack) begin
                cur[bus_ch]     <= bus_nxt;
                pending[bus_ch] <= 1'b0;
                irq_o           <= (bus_nxt == tgt[bus_ch]);
                rr_ptr          <= rr_after;
            end
            if (do_timeout) begin
                err_o  <= 1'b1;
                rr_ptr <= rr_after;
            end
            if (cfg_valid_i) begin
                tgt[cfg_ch_i]  <= cfg_target_i;
                step[cfg_ch_i] <= cfg_step_i;
                if (cfg_step_i == 8'd0 && cfg_target_i != cur[cfg_ch_i])
                    pending[cfg_ch_i] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_seq.sv
// Directed bench for pwm_ramp_seq: ramps, jump, round-robin, ack timeout and reset mid-write.
module tb_pwm_ramp_seq;

    localparam int          NCH      = 8;
    localparam int          TICK_DIV = 64;
    localparam logic [31:0] BASE     = 32'hFEED_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [7:0]  cfg_target = '0;
    logic [7:0]  cfg_step = '0;
    logic        cyc, stb, we, ack, irq, err;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic [7:0]  active;

    logic ack_r = 1'b0;
    logic ack_en = 1'b1;
    logic force_ack = 1'b0;

    int checks = 0;
    int fails = 0;
    int cycle_cnt = 0;
    int irq_cnt = 0;
    int gap_err = 0;
    logic prev_done = 1'b0;

    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    logic [3:0]  wr_sel[$];
    logic        wr_we[$];
    int          wr_cyc[$];

    pwm_ramp_seq #(.NCH(NCH), .BASE_ADR(BASE), .TICK_DIV(TICK_DIV), .ACK_TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ch_i(cfg_ch),
        .cfg_target_i(cfg_target), .cfg_step_i(cfg_step),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_ack_i(ack),
        .active_o(active), .irq_o(irq), .err_o(err)
    );

    always #5 clk = ~clk;

    // Zero-wait registered-ack slave; force_ack injects stray acks.
    always @(posedge clk) ack_r <= ack_en && cyc && stb && !ack_r;
    assign ack = ack_r | force_ack;

    always @(negedge clk) begin
        cycle_cnt++;
        if (irq) irq_cnt++;
        if (prev_done && cyc) gap_err++;
        if (cyc && stb && ack) begin
            wr_adr.push_back(adr);
            wr_dat.push_back(dat);
            wr_sel.push_back(sel);
            wr_we.push_back(we);
            wr_cyc.push_back(cycle_cnt);
        end
        prev_done = cyc && stb && ack;
    end

    task automatic clear_logs();
        wr_adr.delete(); wr_dat.delete(); wr_sel.delete(); wr_we.delete(); wr_cyc.delete();
        irq_cnt = 0;
        gap_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [7:0] t, input logic [7:0] s);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_target = t; cfg_step = s;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k = 0;
        while (wr_dat.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (wr_dat.size() < n) begin
            fails++;
            $display("[TB] FAIL %s: got %0d writes, expected %0d", name, wr_dat.size(), n);
        end
    endtask

    task automatic wait_cyc(input int budget, input string name);
        int k = 0;
        while (!cyc && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (cyc !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s: cyc=%b after %0d cycles, expected 1", name, cyc, k);
        end
    endtask

    task automatic check_write(input int i, input logic [31:0] ea, input logic [31:0] ed, input string name);
        checks++;
        if (i >= wr_dat.size()) begin
            fails++;
            $display("[TB] FAIL %s[%0d]: write missing, expected adr %h dat %h", name, i, ea, ed);
        end else if (wr_adr[i] !== ea || wr_dat[i] !== ed || wr_sel[i] !== 4'b1111 || wr_we[i] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s[%0d]: got adr %h dat %h sel %b we %b, expected adr %h dat %h sel 1111 we 1",
                     name, i, wr_adr[i], wr_dat[i], wr_sel[i], wr_we[i], ea, ed);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cyc, stb, we} !== 3'b000) begin
            fails++; $display("[TB] FAIL reset_ctrl: got %b, expected 000", {cyc, stb, we});
        end
        checks++;
        if (adr !== 32'h0 || dat !== 32'h0 || sel !== 4'h0) begin
            fails++; $display("[TB] FAIL reset_bus: got adr %h dat %h sel %b, expected 0", adr, dat, sel);
        end
        checks++;
        if (active !== 8'h00 || irq !== 1'b0 || err !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_status: got active %h irq %b err %b, expected 0", active, irq, err);
        end
    endtask

    task automatic test_ramp_up();
        logic [7:0] exp_d [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        do_reset();
        cfg(3'd3, 8'h40, 8'h10);
        @(negedge clk);
        checks++;
        if (active[3] !== 1'b1) begin
            fails++; $display("[TB] FAIL ramp_up_active_on: got %b, expected 1", active[3]);
        end
        wait_writes(4, 6 * TICK_DIV, "ramp_up_count");
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) check_write(i, BASE | 32'd3, {24'b0, exp_d[i]}, "ramp_up");
        for (int i = 0; i + 1 < wr_cyc.size() && i < 3; i++) begin
            checks++;
            if (wr_cyc[i + 1] - wr_cyc[i] != TICK_DIV) begin
                fails++;
                $display("[TB] FAIL ramp_up_interval[%0d]: got %0d cycles, expected %0d", i, wr_cyc[i + 1] - wr_cyc[i], TICK_DIV);
            end
        end
        checks++;
        if (irq_cnt != 1 || active[3] !== 1'b0) begin
            fails++; $display("[TB] FAIL ramp_up_done: got irq count %0d active3 %b, expected 1 and 0", irq_cnt, active[3]);
        end
    endtask

    task automatic test_ramp_down();
        logic [7:0] exp_d [4] = '{8'h30, 8'h20, 8'h10, 8'h05};
        do_reset();
        cfg(3'd0, 8'h40, 8'h00);
        wait_writes(1, 20, "ramp_down_setup");
        repeat (5) @(negedge clk);
        clear_logs();
        cfg(3'd0, 8'h05, 8'h10);
        wait_writes(4, 6 * TICK_DIV, "ramp_down_count");
        repeat (TICK_DIV + 10) @(negedge clk);
        for (int i = 0; i < 4; i++) check_write(i, BASE, {24'b0, exp_d[i]}, "ramp_down");
        checks++;
        if (wr_dat.size() != 4 || irq_cnt != 1 || active[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ramp_down_settle: got %0d writes irq %0d active0 %b, expected 4, 1, 0", wr_dat.size(), irq_cnt, active[0]);
        end
    endtask

    task automatic test_jump();
        do_reset();
        cfg(3'd7, 8'hFF, 8'h00);
        wait_cyc(3, "jump_latency");
        repeat (5) @(negedge clk);
        check_write(0, BASE | 32'd7, 32'h0000_00FF, "jump");
        checks++;
        if (wr_dat.size() != 1 || irq_cnt != 1) begin
            fails++; $display("[TB] FAIL jump_irq: got %0d writes irq %0d, expected 1 and 1", wr_dat.size(), irq_cnt);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < NCH; c++) cfg(3'(c), 8'h02, 8'h01);
        wait_writes(16, 4 * TICK_DIV, "rr_count");
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++)
            check_write(i, BASE | 32'(i % NCH), (i < NCH) ? 32'h1 : 32'h2, "rr");
        checks++;
        if (gap_err != 0 || irq_cnt != NCH || active !== 8'h00) begin
            fails++;
            $display("[TB] FAIL rr_gaps_irq: got gaps %0d irq %0d active %h, expected 0, 8, 00", gap_err, irq_cnt, active);
        end
    endtask

    task automatic test_timeout();
        int len = 0;
        do_reset();
        ack_en = 1'b0;
        cfg(3'd1, 8'h20, 8'h00);
        wait_cyc(5, "timeout_start");
        checks++;
        if (dat !== 32'h20 || adr !== (BASE | 32'd1)) begin
            fails++; $display("[TB] FAIL timeout_bus: got adr %h dat %h, expected %h 00000020", adr, dat, BASE | 32'd1);
        end
        while (cyc && len < 40) begin
            len++;
            @(negedge clk);
        end
        checks++;
        if (len != 16 || err !== 1'b1) begin
            fails++; $display("[TB] FAIL timeout_len: got %0d cycles err %b, expected 16 and 1", len, err);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (err !== 1'b1 || wr_dat.size() != 0) begin
            fails++; $display("[TB] FAIL timeout_sticky: got err %b writes %0d, expected 1 and 0", err, wr_dat.size());
        end
        ack_en = 1'b1;
        wait_writes(1, 40, "timeout_retry");
        repeat (4) @(negedge clk);
        check_write(0, BASE | 32'd1, 32'h20, "timeout_retry");
        checks++;
        if (active[1] !== 1'b0 || irq_cnt != 1 || err !== 1'b1) begin
            fails++; $display("[TB] FAIL timeout_after: got active1 %b irq %0d err %b, expected 0, 1, 1", active[1], irq_cnt, err);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        ack_en = 1'b0;
        cfg(3'd2, 8'h33, 8'h00);
        wait_cyc(5, "midrst_start");
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cyc, stb} !== 2'b00 || adr !== 32'h0 || dat !== 32'h0 || sel !== 4'h0) begin
            fails++; $display("[TB] FAIL midrst_bus: got cyc %b stb %b adr %h dat %h sel %b, expected all 0", cyc, stb, adr, dat, sel);
        end
        checks++;
        if (active !== 8'h00 || irq !== 1'b0 || err !== 1'b0) begin
            fails++; $display("[TB] FAIL midrst_status: got active %h irq %b err %b, expected 0", active, irq, err);
        end
        rst = 1'b0;
        clear_logs();
        repeat (2) @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (wr_dat.size() != 0 || irq_cnt != 0 || cyc !== 1'b0) begin
            fails++; $display("[TB] FAIL midrst_late_ack: got writes %0d irq %0d cyc %b, expected 0", wr_dat.size(), irq_cnt, cyc);
        end
        ack_en = 1'b1;
        repeat (TICK_DIV + 10) @(negedge clk);
        checks++;
        if (wr_dat.size() != 0 || active !== 8'h00) begin
            fails++; $display("[TB] FAIL midrst_state: got writes %0d active %h, expected 0 and 00", wr_dat.size(), active);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_jump();
        test_round_robin();
        test_timeout();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
